// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg: shared constants for the load-use scoreboard
package id_scoreboard_pkg;
    localparam logic RstEnable      = 1'b1;
    localparam logic Stop           = 1'b1;
    localparam logic NoStop         = 1'b0;
    localparam int   RegAddrBus     = 5;
    localparam int   LoadLatDefault = 1;
endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// sb_counter: one per-register pending-load countdown cell
module sb_counter
    import id_scoreboard_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_en_i,
    output logic             nz_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // an accepted write overrides the decrement; zero never underflows
    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_en_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end
    // countdown register
    always_ff @(posedge clk) begin
        cnt_q <= (rst == RstEnable) ? '0 : cnt_d;
    end
    assign nz_o = |cnt_q;
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage load-use interlock with configurable load latency (optional ID_SCOREBOARD_STATS_EN stall counter)
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = RegAddrBus,
    parameter int LOAD_LAT = LoadLatDefault,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg1_read_i,
    input  logic [REG_AW-1:0] reg1_addr_i,
    input  logic              reg2_read_i,
    input  logic [REG_AW-1:0] reg2_addr_i,
    input  logic              issue_valid_i,
    input  logic              wreg_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              is_load_i,
    input  logic              hold_i,
    input  logic              flush_i,
`ifdef ID_SCOREBOARD_STATS_EN
    output logic [31:0]       stall_cycles_o,
`endif
    output logic              stallReq,
    output logic [REG_NUM-1:0] pending_o,
    output logic              issue_ack_o
);
    logic [REG_NUM-1:0] pend;
    logic hit1, hit2, wr;
    assign pend[0] = 1'b0;
    // source hazard detection and issue qualification
    always_comb begin
        hit1        = reg1_read_i && reg1_addr_i != '0 && pend[reg1_addr_i];
        hit2        = reg2_read_i && reg2_addr_i != '0 && pend[reg2_addr_i];
        stallReq    = (issue_valid_i && !flush_i && (hit1 || hit2)) ? Stop : NoStop;
        issue_ack_o = issue_valid_i && !stallReq && !hold_i && !flush_i;
        wr          = issue_ack_o && wreg_i && wd_i != '0;
    end
    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .load_i    (wr && wd_i == REG_AW'(r)),
            .load_val_i(is_load_i ? CNT_W'(LOAD_LAT) : '0),
            .dec_en_i  (!hold_i),
            .nz_o      (pend[r])
        );
    end
    assign pending_o = pend;
`ifdef ID_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    // saturating count of unheld stall cycles
    always_ff @(posedge clk) begin
        if (rst == RstEnable) stall_cnt_q <= '0;
        else if (stallReq && !hold_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cycles_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: checks LOAD_LAT=1 and LOAD_LAT=3 scoreboards against a countdown-array model
module tb_id_scoreboard;
    logic clk = 1'b0, rst = 1'b0;
    logic r1 = 0, r2 = 0, v = 0, wreg = 0, ld = 0, hold = 0, fl = 0;
    logic [4:0] a1 = 0, a2 = 0, wd = 0;
    logic st1, st3, ack1, ack3;
    logic [31:0] pd1, pd3;
    logic [31:0] sc1, sc3;
    int compared = 0, mismatched = 0;
    int m [2][32];
    int lat [2] = '{1, 3};
    longint stats [2];
    logic e_st [2], e_ack [2];
    int s1, s3;

    always #5 clk = ~clk;

    id_scoreboard #(.LOAD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .reg1_read_i(r1), .reg1_addr_i(a1), .reg2_read_i(r2), .reg2_addr_i(a2),
        .issue_valid_i(v), .wreg_i(wreg), .wd_i(wd), .is_load_i(ld), .hold_i(hold), .flush_i(fl),
`ifdef ID_SCOREBOARD_STATS_EN
        .stall_cycles_o(sc1),
`endif
        .stallReq(st1), .pending_o(pd1), .issue_ack_o(ack1));
    id_scoreboard #(.LOAD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .reg1_read_i(r1), .reg1_addr_i(a1), .reg2_read_i(r2), .reg2_addr_i(a2),
        .issue_valid_i(v), .wreg_i(wreg), .wd_i(wd), .is_load_i(ld), .hold_i(hold), .flush_i(fl),
`ifdef ID_SCOREBOARD_STATS_EN
        .stall_cycles_o(sc3),
`endif
        .stallReq(st3), .pending_o(pd3), .issue_ack_o(ack3));
`ifndef ID_SCOREBOARD_STATS_EN
    assign sc1 = '0;
    assign sc3 = '0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, iw, input logic [4:0] iwd, input logic il,
                         input logic ir1, input logic [4:0] ia1, input logic ir2, input logic [4:0] ia2,
                         input logic ih, ifl);
        v = iv; wreg = iw; wd = iwd; ld = il; r1 = ir1; a1 = ia1; r2 = ir2; a2 = ia2; hold = ih; fl = ifl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle();
        logic [31:0] ep;
        logic h1, h2;
        #1;
        for (int i = 0; i < 2; i++) begin
            h1 = r1 && a1 != 0 && m[i][a1] != 0;
            h2 = r2 && a2 != 0 && m[i][a2] != 0;
            e_st[i] = v && !fl && (h1 || h2);
            e_ack[i] = v && !e_st[i] && !hold && !fl;
            for (int r = 0; r < 32; r++) ep[r] = m[i][r] != 0;
            chk(i ? "stall3" : "stall1", i ? st3 : st1, e_st[i]);
            chk(i ? "ack3" : "ack1", i ? ack3 : ack1, e_ack[i]);
            chk(i ? "pend3" : "pend1", i ? pd3 : pd1, ep);
`ifdef ID_SCOREBOARD_STATS_EN
            chk(i ? "stats3" : "stats1", i ? sc3 : sc1, stats[i]);
`endif
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) m[i][r] = 0;
                stats[i] = 0;
            end else if (!hold) begin
                for (int r = 0; r < 32; r++) if (m[i][r] > 0) m[i][r]--;
                if (e_ack[i] && wreg && wd != 0) m[i][wd] = ld ? lat[i] : 0;
                if (e_st[i] && stats[i] < 64'hFFFF_FFFF) stats[i]++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            stats[i] = 0;
            for (int r = 0; r < 32; r++) m[i][r] = 0;
        end
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_pend1", pd1, 0);
        chk("rst_pend3", pd3, 0);
        chk("rst_stall", {st1, st3, ack1, ack3}, 0);
        cycle();
        // LW $3 then a consumer of $3 held in decode
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 8, 0, 1, 3, 0, 0, 0, 0);
        s1 = 0; s3 = 0;
        #1;
        chk("lu_t1_stall1", st1, 1);
        chk("lu_t1_pend3", pd1[3], 1);
        for (int k = 0; k < 6; k++) begin
            #1;
            s1 += int'(st1);
            s3 += int'(st3);
            if (k == 1) chk("lu_t2_ack1", ack1, 1);
            cycle();
        end
        chk("lu_stalls1", s1, 1);
        chk("lu_stalls3", s3, 3);
`ifdef ID_SCOREBOARD_STATS_EN
        chk("lu_statcnt3", sc3, 3);
`endif
        // LW $0 then reader of $0
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        #1;
        chk("r0_stall", {st1, st3}, 0);
        chk("r0_pend", pd1 | pd3, 0);
        cycle();
        // LW $4, younger ORI to $4, then reader of $4
        drive(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        #1;
        chk("waw_stall", {st1, st3}, 0);
        cycle();
        // LW $6 then a 4-cycle hold
        drive(1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) begin
            #1;
            chk("hold_pend6", {pd1[6], pd3[6]}, 2'b11);
            cycle();
        end
        idle();
        repeat (4) cycle();
        // consumer of $7 flushed, then reset mid-countdown
        drive(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 9, 1, 1, 7, 1, 7, 0, 1);
        #1;
        chk("flush_out", {st3, ack3, pd3[9]}, 3'b000);
        cycle();
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        #1;
        chk("midrst_pend", pd1 | pd3, 0);
        cycle();
        // random traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            rst = $urandom_range(0, 59) == 0;
            cycle();
        end
        rst = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
